// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the CPU/VGA data-RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF         = 14;
  localparam int unsigned DEPTH_DEF          = 9601;
  localparam int unsigned MAX_VGA_STREAK_DEF = 4;
  localparam int unsigned DATA_W             = 32;

  typedef enum logic {
    IDLE,
    CPU_RD_PEND
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VGA
  } owner_t;

endpackage

// File: rtl/arb_priority.sv
// Fixed VGA-over-CPU priority with a starvation streak counter that
// forces a CPU grant after MAX_VGA_STREAK consecutive VGA wins.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_VGA_STREAK = MAX_VGA_STREAK_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_cpu_req,
  input  logic i_vga_req,
  output logic o_grant_cpu,
  output logic o_grant_vga
);

  localparam int unsigned STREAK_W = $clog2(MAX_VGA_STREAK + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_starved;

  assign w_starved   = i_cpu_req && (r_streak == STREAK_W'(MAX_VGA_STREAK));
  assign o_grant_vga = !reset && i_vga_req && !w_starved;
  assign o_grant_cpu = !reset && i_cpu_req && !o_grant_vga;

  // Streak only grows while the CPU is actually waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset || !i_cpu_req || o_grant_cpu) begin
      r_streak <= '0;
    end else if (o_grant_vga && (r_streak != STREAK_W'(MAX_VGA_STREAK))) begin
      r_streak <= r_streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port synchronous-read data RAM shared between the CPU data port
// and the VGA scan-out fetcher; stalls the CPU while its access is pending.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned MAX_VGA_STREAK = MAX_VGA_STREAK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t r_state;
  logic   r_vga_rvalid;
  logic   r_cpu_oor;
  logic   r_vga_oor;

  logic   w_cpu_elig;
  logic   w_gnt_cpu;
  logic   w_gnt_vga;
  logic   w_cpu_in_range;
  logic   w_vga_in_range;
  logic   w_cpu_wr;
  owner_t w_owner;

  // In CPU_RD_PEND the CPU request is the one completing, so it does not compete.
  assign w_cpu_elig = cpu_req && (r_state == IDLE);

  arb_priority #(
    .MAX_VGA_STREAK(MAX_VGA_STREAK)
  ) u_arb_priority (
    .clk        (clk),
    .reset      (reset),
    .i_cpu_req  (w_cpu_elig),
    .i_vga_req  (vga_req),
    .o_grant_cpu(w_gnt_cpu),
    .o_grant_vga(w_gnt_vga)
  );

  assign w_cpu_in_range = 32'(cpu_addr) < DEPTH;
  assign w_vga_in_range = 32'(vga_addr) < DEPTH;

  assign w_owner  = w_gnt_vga ? OWN_VGA : (w_gnt_cpu ? OWN_CPU : OWN_NONE);
  assign w_cpu_wr = (w_owner == OWN_CPU) && cpu_we;

  assign ram_en    = (w_owner != OWN_NONE);
  assign ram_we    = w_cpu_wr && w_cpu_in_range;
  assign ram_addr  = (w_owner == OWN_VGA) ? vga_addr : cpu_addr;
  assign ram_wdata = cpu_wdata;

  assign vga_gnt    = w_gnt_vga;
  assign vga_rvalid = r_vga_rvalid && !reset;
  assign vga_rdata  = (vga_rvalid && !r_vga_oor) ? ram_rdata : '0;

  assign cpu_stall = reset ? cpu_req
                           : (cpu_req && !w_cpu_wr && (r_state != CPU_RD_PEND));
  assign cpu_rdata = (!reset && (r_state == CPU_RD_PEND) && !r_cpu_oor) ? ram_rdata : '0;

  // Read-return tracking: a CPU read holds the FSM for one data-return cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_vga_rvalid <= 1'b0;
      r_cpu_oor    <= 1'b0;
      r_vga_oor    <= 1'b0;
    end else begin
      r_vga_rvalid <= w_gnt_vga;
      if (w_gnt_vga) r_vga_oor <= !w_vga_in_range;
      if (w_gnt_cpu) r_cpu_oor <= !w_cpu_in_range;
      case (r_state)
        IDLE:        r_state <= (w_gnt_cpu && !cpu_we) ? CPU_RD_PEND : IDLE;
        CPU_RD_PEND: r_state <= IDLE;
        default:     r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a bench-side RAM and
// a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DEPTH     = 9601;
  localparam int unsigned MAXS      = 4;
  localparam int unsigned RAM_WORDS = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cpu_req, cpu_we, vga_req;
  logic [ADDR_W-1:0] cpu_addr, vga_addr, ram_addr;
  logic [31:0]       cpu_wdata, cpu_rdata, vga_rdata, ram_wdata, ram_rdata;
  logic              cpu_stall, vga_gnt, vga_rvalid, ram_en, ram_we;

  mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_VGA_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_val(input int unsigned i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Bench RAM: loaded on the first edge, then behaves as a sync-read single port.
  logic [31:0] ram [RAM_WORDS];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(RAM_WORDS); i++) ram[i] <= init_val(32'(i));
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [RAM_WORDS];
  bit          m_pend, m_vvalid;
  logic [31:0] m_pend_data, m_vdata;
  int unsigned m_streak;
  bit          e_stall, e_vgnt;
  int          n_cmp, n_bad;

  logic              s_stall, s_en, s_we, s_vgnt, s_vval;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata, s_crd, s_vrd;

  function automatic logic [31:0] ref_rd(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)      return ADDR_W'($urandom_range(0, 31));
    else if (r < 9) return ADDR_W'($urandom_range(9598, 9603));
    else            return ADDR_W'($urandom_range(9604, 16383));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict, check mid-cycle, then advance the model.
  task automatic cycle(input logic rst, input logic creq, input logic cwe,
                       input logic [ADDR_W-1:0] caddr, input logic [31:0] cwd,
                       input logic vreq, input logic [ADDR_W-1:0] vaddr);
    bit contend, vwin, cwin, x_en, x_we;
    logic [ADDR_W-1:0] x_addr;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    vga_req = vreq; vga_addr = vaddr;
    contend = creq && !m_pend;
    vwin    = !rst && vreq && !(contend && (m_streak >= MAXS));
    cwin    = !rst && contend && !vwin;
    x_en    = vwin || cwin;
    x_we    = cwin && cwe && (32'(caddr) < DEPTH);
    x_addr  = vwin ? vaddr : caddr;
    e_vgnt  = vwin;
    e_stall = rst ? creq : (creq && !(cwin && cwe) && !m_pend);
    @(negedge clk);
    s_stall = cpu_stall; s_en = ram_en; s_we = ram_we; s_vgnt = vga_gnt; s_vval = vga_rvalid;
    s_addr = ram_addr; s_wdata = ram_wdata; s_crd = cpu_rdata; s_vrd = vga_rdata;
    check("cpu_stall", 32'(s_stall), 32'(e_stall));
    check("ram_en", 32'(s_en), 32'(x_en));
    check("ram_we", 32'(s_we), 32'(x_we));
    check("vga_gnt", 32'(s_vgnt), 32'(vwin));
    if (x_en) check("ram_addr", 32'(s_addr), 32'(x_addr));
    if (x_we) check("ram_wdata", s_wdata, cwd);
    if (rst) begin
      check("rst_cpu_rdata", s_crd, 32'h0);
      check("rst_vga_rvalid", 32'(s_vval), 32'h0);
      check("rst_vga_rdata", s_vrd, 32'h0);
    end else begin
      check("vga_rvalid", 32'(s_vval), 32'(m_vvalid));
      if (m_vvalid) check("vga_rdata", s_vrd, m_vdata);
      if (m_pend) check("cpu_rdata", s_crd, m_pend_data);
    end
    @(posedge clk); #1;
    if (rst) begin
      m_pend = 1'b0; m_vvalid = 1'b0; m_streak = 0;
    end else begin
      if (vwin) m_vdata = ref_rd(vaddr);
      if (cwin && !cwe) m_pend_data = ref_rd(caddr);
      if (x_we) ref_mem[caddr] = cwd;
      m_vvalid = vwin;
      m_pend   = cwin && !cwe;
      if (!contend || cwin) m_streak = 0;
      else if (m_streak < MAXS) m_streak++;
    end
  endtask

  initial begin
    logic              c_req, c_we, v_req, rst;
    logic [ADDR_W-1:0] c_addr, v_addr, va;
    logic [31:0]       c_wd;
    n_cmp = 0; n_bad = 0;
    m_pend = 1'b0; m_vvalid = 1'b0; m_streak = 0; m_pend_data = '0; m_vdata = '0;
    e_stall = 1'b0; e_vgnt = 1'b0;
    for (int i = 0; i < int'(RAM_WORDS); i++) ref_mem[i] = init_val(32'(i));
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    @(posedge clk); #1;

    // Reset: no RAM access, stall follows cpu_req
    cycle(1'b1, 1'b1, 1'b0, 14'd3, 32'h0, 1'b1, 14'd9);
    check("rst_stall_eq_req", 32'(s_stall), 32'd1);
    check("rst_no_ram", 32'(s_en), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 14'd3, 32'h0, 1'b0, 14'd9);
    check("rst_stall_low", 32'(s_stall), 32'd0);

    // Uncontended store
    cycle(1'b0, 1'b1, 1'b1, 14'd5, 32'hDEADBEEF, 1'b0, 14'd0);
    check("sw_en", 32'(s_en), 32'd1);
    check("sw_we", 32'(s_we), 32'd1);
    check("sw_addr", 32'(s_addr), 32'd5);
    check("sw_stall", 32'(s_stall), 32'd0);

    // Uncontended load of the stored word
    cycle(1'b0, 1'b1, 1'b0, 14'd5, 32'h0, 1'b0, 14'd0);
    check("lw_c0_stall", 32'(s_stall), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 14'd5, 32'h0, 1'b0, 14'd0);
    check("lw_c1_stall", 32'(s_stall), 32'd0);
    check("lw_c1_rdata", s_crd, 32'hDEADBEEF);
    check("lw_c1_no_reaccess", 32'(s_en), 32'd0);

    // Continuous VGA against a CPU load: four VGA wins, then the CPU
    cycle(1'b0, 1'b1, 1'b1, 14'd7, 32'h0BADF00D, 1'b0, 14'd0);
    va = 14'd200;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 14'd7, 32'h0, 1'b1, va);
      if (e_vgnt) va = va + 14'd1;
      check("starve_vga_gnt", 32'(s_vgnt), (k == 4) ? 32'd0 : 32'd1);
      check("starve_stall", 32'(s_stall), (k < 5) ? 32'd1 : 32'd0);
      if (k == 4) check("starve_cpu_addr", 32'(s_addr), 32'd7);
    end
    check("starve_rdata", s_crd, 32'h0BADF00D);
    cycle(1'b0, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0, 14'd0);

    // VGA burst 100..103
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 14'd0, 32'h0, (k < 4), 14'(100 + k));
      check("burst_gnt", 32'(s_vgnt), (k < 4) ? 32'd1 : 32'd0);
      check("burst_rvalid", 32'(s_vval), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("burst_rdata", s_vrd, init_val(32'(99 + k)));
    end

    // Out-of-range and last-valid-address accesses
    cycle(1'b0, 1'b1, 1'b1, 14'd9700, 32'h0000CAFE, 1'b0, 14'd0);
    check("oor_sw_we", 32'(s_we), 32'd0);
    check("oor_sw_stall", 32'(s_stall), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 14'd9700, 32'h0, 1'b0, 14'd0);
    check("oor_lw_c0_stall", 32'(s_stall), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 14'd9700, 32'h0, 1'b0, 14'd0);
    check("oor_lw_rdata", s_crd, 32'h0);
    check("oor_lw_stall", 32'(s_stall), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 14'd9600, 32'h0000600D, 1'b0, 14'd0);
    check("last_sw_we", 32'(s_we), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 14'd9600, 32'h0, 1'b0, 14'd0);
    cycle(1'b0, 1'b1, 1'b0, 14'd9600, 32'h0, 1'b0, 14'd0);
    check("last_lw_rdata", s_crd, 32'h0000600D);
    cycle(1'b0, 1'b1, 1'b1, 14'd9601, 32'h11111111, 1'b0, 14'd0);
    check("first_oor_sw_we", 32'(s_we), 32'd0);

    // Reset while a CPU read is pending
    cycle(1'b0, 1'b1, 1'b0, 14'd10, 32'h0, 1'b0, 14'd0);
    check("rp_grant_stall", 32'(s_stall), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 14'd10, 32'h0, 1'b1, 14'd60);
    check("rp_no_ram", 32'(s_en), 32'd0);
    check("rp_no_vga_gnt", 32'(s_vgnt), 32'd0);
    check("rp_no_rdata", s_crd, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 14'd10, 32'h0, 1'b0, 14'd0);
    check("rp_idle_stall", 32'(s_stall), 32'd1);
    check("rp_rvalid_low", 32'(s_vval), 32'd0);
    check("rp_reissue", 32'(s_en), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 14'd10, 32'h0, 1'b0, 14'd0);
    check("rp_rdata", s_crd, init_val(32'd10));
    cycle(1'b0, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0, 14'd0);

    // Randomized traffic; requesters hold their request until it is served
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0; v_req = 1'b0; v_addr = '0;
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(c_req && e_stall)) begin
        c_req  = ($urandom_range(0, 99) < 60);
        c_we   = 1'($urandom_range(0, 1));
        c_addr = pick_addr();
        c_wd   = $urandom;
      end
      if (!(v_req && !e_vgnt)) begin
        v_req  = ($urandom_range(0, 99) < 50);
        v_addr = pick_addr();
      end
      cycle(rst, c_req, c_we, c_addr, c_wd, v_req, v_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
